ram_cmd_arbiter: RTL

RAM_CMD_ARBITER -- requirements
Module: ram_cmd_arbiter

---
 rtl/ram_cmd_arbiter_if.sv | 36 +++
 rtl/ram_cmd_arbiter.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/ram_cmd_arbiter_if.sv
// ram_cmd_arbiter_if: requester, RAM and status signals of ram_cmd_arbiter
interface ram_cmd_arbiter_if #(
    parameter int MEM_DEPTH = 256
);
    localparam int ADDR_SIZE = $clog2(MEM_DEPTH);
    localparam int CMD_W     = ADDR_SIZE + 2;

    logic                 req_valid_a;
    logic                 req_valid_b;
    logic [CMD_W-1:0]     req_data_a;
    logic [CMD_W-1:0]     req_data_b;
    logic                 req_ready_a;
    logic                 req_ready_b;
    logic                 rsp_valid_a;
    logic                 rsp_valid_b;
    logic [ADDR_SIZE-1:0] rsp_data;
    logic                 ram_rx_valid;
    logic [CMD_W-1:0]     ram_rx_data;
    logic                 ram_tx_valid;
    logic [ADDR_SIZE-1:0] ram_tx_data;
    logic                 lock_err;
    logic [15:0]          grant_cnt_a;
    logic [15:0]          grant_cnt_b;

    modport slave (
        input  req_valid_a, req_valid_b, req_data_a, req_data_b, ram_tx_valid, ram_tx_data,
        output req_ready_a, req_ready_b, rsp_valid_a, rsp_valid_b, rsp_data,
               ram_rx_valid, ram_rx_data, lock_err, grant_cnt_a, grant_cnt_b
    );

    modport master (
        output req_valid_a, req_valid_b, req_data_a, req_data_b, ram_tx_valid, ram_tx_data,
        input  req_ready_a, req_ready_b, rsp_valid_a, rsp_valid_b, rsp_data,
               ram_rx_valid, ram_rx_data, lock_err, grant_cnt_a, grant_cnt_b
    );
endinterface

// File: rtl/ram_cmd_arbiter.sv
// ram_cmd_arbiter: round-robin two-requester RAM command arbiter with address/data pair locking; ARB_STATS_EN adds saturating grant counters
module ram_cmd_arbiter #(
    parameter int MEM_DEPTH    = 256,
    parameter int LOCK_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    ram_cmd_arbiter_if.slave  bus
);
    localparam int ADDR_SIZE = $clog2(MEM_DEPTH);
    localparam int CMD_W     = ADDR_SIZE + 2;
    localparam int TW        = $clog2(LOCK_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, GRANT, LOCKED, WAIT_RD} state_t;

    state_t               r_state, w_next;
    logic                 r_owner;
    logic                 r_last;
    logic [1:0]           r_pend;
    logic [TW-1:0]        r_timer;
    logic                 r_rd_arm;
    logic                 r_rx_valid;
    logic [CMD_W-1:0]     r_rx_data;
    logic                 r_rsp_a, r_rsp_b;
    logic [ADDR_SIZE-1:0] r_rsp_data;
    logic                 r_lock_err;

    logic                 w_ready, w_valid, w_xfer, w_sel, w_grant, w_timeout, w_rd_done;
    logic [CMD_W-1:0]     w_cmd;
    logic [1:0]           w_op;

    assign w_ready   = (r_state == GRANT) || (r_state == LOCKED);
    assign w_valid   = r_owner ? bus.req_valid_b : bus.req_valid_a;
    assign w_cmd     = r_owner ? bus.req_data_b : bus.req_data_a;
    assign w_op      = w_cmd[CMD_W-1 -: 2];
    assign w_xfer    = w_ready && w_valid;
    assign w_sel     = (bus.req_valid_a && bus.req_valid_b) ? !r_last : bus.req_valid_b;
    assign w_grant   = (r_state == IDLE) && (bus.req_valid_a || bus.req_valid_b);
    assign w_timeout = (r_state == LOCKED) && !w_xfer && (r_timer == TW'(LOCK_TIMEOUT - 1));
    assign w_rd_done = (r_state == WAIT_RD) && r_rd_arm && bus.ram_tx_valid;

    assign bus.req_ready_a  = w_ready && !r_owner;
    assign bus.req_ready_b  = w_ready && r_owner;
    assign bus.ram_rx_valid = r_rx_valid;
    assign bus.ram_rx_data  = r_rx_data;
    assign bus.rsp_valid_a  = r_rsp_a;
    assign bus.rsp_valid_b  = r_rsp_b;
    assign bus.rsp_data     = r_rsp_data;
    assign bus.lock_err     = r_lock_err;

    // Next state: a pair-opening opcode locks the owner until the matching second half or a timeout
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_grant ? GRANT : IDLE;
            GRANT:   if (w_xfer) w_next = (w_op == 2'b11) ? WAIT_RD : (w_op == 2'b01) ? IDLE : LOCKED;
            LOCKED:  if (w_xfer) w_next = (w_op == 2'b01 && r_pend == 2'b00) ? IDLE :
                                          (w_op == 2'b11 && r_pend == 2'b10) ? WAIT_RD : LOCKED;
                     else if (w_timeout) w_next = IDLE;
            WAIT_RD: w_next = w_rd_done ? IDLE : WAIT_RD;
            default: w_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Owner and round-robin history, captured when a grant starts; B counts as last so A wins first
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner <= 1'b0;
            r_last  <= 1'b1;
        end else if (w_grant) begin
            r_owner <= w_sel;
            r_last  <= w_sel;
        end
    end

    // Pending pair opener (00 or 10) of the current owner
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                   r_pend <= 2'b00;
        else if (w_xfer && !w_op[0]) r_pend <= w_op;
    end

    // Lock timer counts idle LOCKED cycles and restarts on any transfer
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                              r_timer <= '0;
        else if (w_xfer || r_state != LOCKED) r_timer <= '0;
        else                                  r_timer <= r_timer + 1'b1;
    end

    // Read return is ignored during the first WAIT_RD cycle so the RAM has seen the command
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_rd_arm <= 1'b0;
        else     r_rd_arm <= (r_state == WAIT_RD) && !w_rd_done;
    end

    // Registered command forwarding to the RAM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_valid <= 1'b0;
            r_rx_data  <= '0;
        end else begin
            r_rx_valid <= w_xfer;
            if (w_xfer) r_rx_data <= w_cmd;
        end
    end

    // Read response capture and one-cycle pulse towards the owner, plus timeout pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_a    <= 1'b0;
            r_rsp_b    <= 1'b0;
            r_rsp_data <= '0;
            r_lock_err <= 1'b0;
        end else begin
            r_rsp_a    <= w_rd_done && !r_owner;
            r_rsp_b    <= w_rd_done && r_owner;
            r_lock_err <= w_timeout;
            if (w_rd_done) r_rsp_data <= bus.ram_tx_data;
        end
    end

`ifdef ARB_STATS_EN
    logic [15:0] r_cnt_a, r_cnt_b;

    // Saturating per-requester grant counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt_a <= '0;
            r_cnt_b <= '0;
        end else if (w_grant) begin
            if (!w_sel && r_cnt_a != 16'hFFFF) r_cnt_a <= r_cnt_a + 16'd1;
            if (w_sel && r_cnt_b != 16'hFFFF)  r_cnt_b <= r_cnt_b + 16'd1;
        end
    end

    assign bus.grant_cnt_a = r_cnt_a;
    assign bus.grant_cnt_b = r_cnt_b;
`else
    assign bus.grant_cnt_a = '0;
    assign bus.grant_cnt_b = '0;
`endif
endmodule
